// File: rtl/merge_dataless_rr_arbiter.sv
// ---------------------------------------------------------------------------
// merge_dataless_rr_arbiter
//   Round-robin merge of SIZE dataless handshake channels into one output
//   channel through a single registered slot (1-cycle latency, 1 token/cycle).
//   The number of the winning input travels with the token on `index`.
//
// Ports
//   clk         in   1            clock, rising edge
//   rst         in   1            asynchronous reset, active low
//   ins_valid   in   SIZE         input i holds a token
//   ins_ready   out  SIZE         input i token consumed this cycle (one-hot/zero)
//   outs_valid  out  1            output slot holds a token (registered)
//   outs_ready  in   1            consumer takes the token this cycle
//   index       out  INDEX_WIDTH  input that produced the held token (registered)
// ---------------------------------------------------------------------------
module merge_dataless_rr_arbiter #(
  parameter int unsigned SIZE        = 2,
  parameter int unsigned INDEX_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SIZE-1:0]        ins_valid,
  output logic [SIZE-1:0]        ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index
);

  // Pointer starts at the last input so that input 0 is scanned first.
  localparam logic [INDEX_WIDTH-1:0] LAST_RST = INDEX_WIDTH'(SIZE - 1);

  logic                   full_q, full_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [INDEX_WIDTH-1:0] last_q, last_d;

  logic                   any_valid;
  logic                   can_accept;
  logic                   accept;
  logic [INDEX_WIDTH-1:0] win;
  logic                   found;
  int unsigned            cand;

  assign any_valid  = |ins_valid;
  assign can_accept = !full_q || outs_ready;
  // No grant may be issued while reset is held.
  assign accept     = rst && can_accept && any_valid;

  // Round-robin scan: last_q+1, last_q+2, ... wrapping, last_q itself checked last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= SIZE; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= SIZE) begin
        cand = cand - SIZE;
      end
      if (!found && ins_valid[INDEX_WIDTH'(cand)]) begin
        found = 1'b1;
        win   = INDEX_WIDTH'(cand);
      end
    end
  end

  // Grant is one-hot on the winner, and only when the slot can take a token.
  always_comb begin
    ins_ready = '0;
    if (accept) begin
      ins_ready[win] = 1'b1;
    end
  end

  // Slot next-state: reload on accept (even while draining), empty on pure drain.
  always_comb begin
    full_d = full_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (accept) begin
      full_d = 1'b1;
      idx_d  = win;
      last_d = win;
    end else if (full_q && outs_ready) begin
      full_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      idx_q  <= '0;
      last_q <= LAST_RST;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign outs_valid = full_q;
  assign index      = idx_q;

endmodule

// File: tb/tb_merge_dataless_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_merge_dataless_rr_arbiter
//   Directed bench for the round-robin dataless merge with SIZE=4, 2 and 1
//   instances sharing clock and reset. Inputs change 1 time unit after the
//   rising edge; combinational grants are sampled 1 unit later, registered
//   outputs 1 unit after the following edge.
// ---------------------------------------------------------------------------
module tb_merge_dataless_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [3:0] v4 = '0, r4;
  logic       or4 = 1'b0, ov4;
  logic [1:0] ix4;

  logic [1:0] v2 = '0, r2;
  logic       or2 = 1'b0, ov2;
  logic [0:0] ix2;

  logic [0:0] v1 = '0, r1;
  logic       or1 = 1'b0, ov1;
  logic [0:0] ix1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  merge_dataless_rr_arbiter #(.SIZE(4)) u4 (
    .clk(clk), .rst(rst), .ins_valid(v4), .ins_ready(r4),
    .outs_valid(ov4), .outs_ready(or4), .index(ix4)
  );

  merge_dataless_rr_arbiter #(.SIZE(2)) u2 (
    .clk(clk), .rst(rst), .ins_valid(v2), .ins_ready(r2),
    .outs_valid(ov2), .outs_ready(or2), .index(ix2)
  );

  merge_dataless_rr_arbiter #(.SIZE(1)) u1 (
    .clk(clk), .rst(rst), .ins_valid(v1), .ins_ready(r1),
    .outs_valid(ov1), .outs_ready(or1), .index(ix1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bit_pos(input logic [3:0] v);
    int p;
    p = -1;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) p = i;
    end
    return p;
  endfunction

  int          tok_in;
  int          tok_out;
  int          gpos;
  logic [3:0]  r_s;
  logic        had;

  initial begin
    // 1: reset with both SIZE=2 inputs valid
    v2 = 2'b11;
    #1;
    chk("rst_ov2", 32'(ov2), 32'd0);
    chk("rst_r2", 32'(r2), 32'd0);
    chk("rst_ix2", 32'(ix2), 32'd0);
    chk("rst_ov4", 32'(ov4), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rel_r2", 32'(r2), 32'b01);
    tick();
    chk("rel_ov2", 32'(ov2), 32'd1);
    chk("rel_ix2", 32'(ix2), 32'd0);
    #1;
    chk("rel_stall_r2", 32'(r2), 32'd0);
    v2 = 2'b00;

    // 2: fairness, all valid and always ready -> 0,1,2,3,0,1,2
    v4  = 4'b1111;
    or4 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("fair_r4_%0d", i), 32'(r4), 32'(4'b0001 << (i % 4)));
      tick();
      chk($sformatf("fair_ov4_%0d", i), 32'(ov4), 32'd1);
      chk($sformatf("fair_ix4_%0d", i), 32'(ix4), 32'(i % 4));
    end

    // 3: backpressure with index 2 held
    or4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_r4_%0d", i), 32'(r4), 32'd0);
      tick();
      chk($sformatf("bp_ov4_%0d", i), 32'(ov4), 32'd1);
      chk($sformatf("bp_ix4_%0d", i), 32'(ix4), 32'd2);
    end
    or4 = 1'b1;
    #1;
    chk("bp_rel_r4", 32'(r4), 32'b1000);
    tick();
    chk("bp_rel_ix4", 32'(ix4), 32'd3);
    chk("bp_rel_ov4", 32'(ov4), 32'd1);

    // 4: skip and wrap (last grant 3)
    v4 = 4'b0100;
    #1;
    chk("skip_r4", 32'(r4), 32'b0100);
    tick();
    chk("skip_ix4", 32'(ix4), 32'd2);
    v4 = 4'b0101;
    #1;
    chk("wrap_r4", 32'(r4), 32'b0001);
    tick();
    chk("wrap_ix4", 32'(ix4), 32'd0);

    // 5: drain to empty, pointer kept at 0
    v4 = 4'b0000;
    #1;
    chk("drain_r4", 32'(r4), 32'd0);
    tick();
    chk("drain_ov4", 32'(ov4), 32'd0);
    chk("drain_ix4", 32'(ix4), 32'd0);
    tick();
    chk("idle_ov4", 32'(ov4), 32'd0);
    v4 = 4'b1111;
    #1;
    chk("after_drain_r4", 32'(r4), 32'b0010);
    tick();
    chk("after_drain_ix4", 32'(ix4), 32'd1);
    chk("after_drain_ov4", 32'(ov4), 32'd1);

    // 6: reset while stalled
    or4 = 1'b0;
    tick();
    chk("stall_ix4", 32'(ix4), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_ov4", 32'(ov4), 32'd0);
    chk("midrst_ix4", 32'(ix4), 32'd0);
    chk("midrst_r4", 32'(r4), 32'd0);
    rst = 1'b1;
    #1;
    chk("postrst_r4", 32'(r4), 32'b0001);
    tick();
    chk("postrst_ix4", 32'(ix4), 32'd0);
    chk("postrst_ov4", 32'(ov4), 32'd1);

    // SIZE=1 behaves as a one-slot buffer
    v1  = 1'b1;
    or1 = 1'b0;
    #1;
    chk("s1_r1", 32'(r1), 32'd1);
    tick();
    chk("s1_ov1", 32'(ov1), 32'd1);
    chk("s1_ix1", 32'(ix1), 32'd0);
    #1;
    chk("s1_full_r1", 32'(r1), 32'd0);
    v1  = 1'b0;
    or1 = 1'b1;
    tick();
    chk("s1_drain_ov1", 32'(ov1), 32'd0);

    // Random run with handshake-respecting sources: tokens in == tokens out
    tok_in  = 1;  // token already held from the post-reset grant above
    tok_out = 0;
    r_s     = '0;
    for (int c = 0; c < 200; c++) begin
      v4  = (v4 & ~r_s) | 4'($urandom_range(0, 15));
      or4 = 1'($urandom_range(0, 1));
      #1;
      r_s = r4;
      if (!$onehot0(r_s)) begin
        chk($sformatf("rnd_onehot_%0d", c), 32'(r_s), 32'd0);
      end
      if ((r_s & ~v4) != 4'b0000) begin
        chk($sformatf("rnd_subset_%0d", c), 32'(r_s & ~v4), 32'd0);
      end
      if (ov4 && or4) tok_out++;
      had  = (r_s != 4'b0000);
      gpos = bit_pos(r_s);
      if (had) tok_in++;
      tick();
      if (had) begin
        chk($sformatf("rnd_ix4_%0d", c), 32'(ix4), 32'(gpos));
        chk($sformatf("rnd_ov4_%0d", c), 32'(ov4), 32'd1);
      end
    end
    v4  = 4'b0000;
    or4 = 1'b1;
    r_s = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (ov4) tok_out++;
      tick();
    end
    chk("rnd_empty_ov4", 32'(ov4), 32'd0);
    chk("rnd_tokens", 32'(tok_out), 32'(tok_in));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
